input_event_controller: RTL and testbench

INPUT_EVENT_CONTROLLER -- requirements
Module: input_event_controller

---
 rtl/input_event_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_input_event_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_event_controller.sv
// input_event_controller: debounced button events queued for a CPU.
// Each raw button is synchronised and debounced. Press/release edges become
// pending events that are arbitrated lowest-index-first into a
// first-word-fall-through FIFO, with a sticky overflow flag for lost events.
// Optional feature: define INPUT_EVENT_AUTO_REPEAT_EN to add per-channel
// auto-repeat events (type 2'b10) while a button is held.
module input_event_controller #(
  parameter int NUM_BTNS        = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  localparam int IDX_W = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1,
  localparam int EVT_W = 2 + IDX_W + NUM_BTNS,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                sys_clock,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] buttons_in,
  input  logic                cpu_read_en,
  input  logic                overflow_clr,
  output logic [EVT_W-1:0]    data_to_cpu,
  output logic                fifo_empty,
  output logic                fifo_full,
  output logic [CNT_W-1:0]    fifo_count,
  output logic                overflow
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

  // Event type field; 2'b11 is reserved and never produced.
  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_RELEASE = 2'b01,
    EVT_REPEAT  = 2'b10,
    EVT_RSVD    = 2'b11
  } evt_type_e;

  logic [NUM_BTNS-1:0] sync1, sync2;
  logic [NUM_BTNS-1:0] db, db_prev;
  logic [DB_W-1:0]     db_cnt [NUM_BTNS];

  logic [NUM_BTNS-1:0] rpt_fire;
  logic [NUM_BTNS-1:0] ev_fire;
  evt_type_e           ev_type [NUM_BTNS];

  logic [NUM_BTNS-1:0] pend;
  evt_type_e           pend_type [NUM_BTNS];

  logic                grant_vld;
  logic [IDX_W-1:0]    grant_idx;
  evt_type_e           grant_type;
  logic [NUM_BTNS-1:0] grant_oh;
  logic                overwrite;

  logic [EVT_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                pop, push, drop;

  // Two-flop synchroniser on every raw button input.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= buttons_in;
      sync2 <= sync1;
    end
  end

  // Debounce: count cycles of disagreement, flip the level once the count hits the limit.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < NUM_BTNS; i++) db_cnt[i] <= '0;
    end else begin
      db_prev <= db;
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

`ifdef INPUT_EVENT_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

  logic [RPT_W-1:0]    rpt_cnt [NUM_BTNS];
  logic [NUM_BTNS-1:0] rpt_first;

  // Repeat fires after the initial delay, then at the repeat period, while held.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      rpt_fire[i] = db[i] & db_prev[i] &
                    (rpt_first[i] ? (rpt_cnt[i] == RPT_W'(REPEAT_DELAY - 1))
                                  : (rpt_cnt[i] == RPT_W'(REPEAT_PERIOD - 1)));
    end
  end

  // Repeat timer: idle unless held, restarts from zero after each repeat.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      rpt_first <= '1;
      for (int i = 0; i < NUM_BTNS; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (!(db[i] && db_prev[i])) begin
          rpt_cnt[i]   <= '0;
          rpt_first[i] <= 1'b1;
        end else if (rpt_fire[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_first[i] <= 1'b0;
        end else begin
          rpt_cnt[i]   <= rpt_cnt[i] + RPT_W'(1);
        end
      end
    end
  end
`else
  // Repeat timing parameters have no effect in this build; kept referenced only.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rpt_fire = '0;
`endif

  // Classify this cycle's new event per channel (press, release or repeat).
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    ev_fire = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      ev_type[i] = EVT_PRESS;
      if (db[i] && !db_prev[i]) begin
        ev_fire[i] = 1'b1;
      end else if (!db[i] && db_prev[i]) begin
        ev_fire[i] = 1'b1;
        ev_type[i] = EVT_RELEASE;
      end else if (rpt_fire[i]) begin
        ev_fire[i] = 1'b1;
        ev_type[i] = EVT_REPEAT;
      end
    end
  end

  // Fixed-priority arbiter: lowest-index pending channel wins.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_type = EVT_PRESS;
    grant_oh   = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        grant_vld   = 1'b1;
        grant_idx   = IDX_W'(i);
        grant_type  = pend_type[i];
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
      end
    end
  end

  assign pop       = cpu_read_en & ~fifo_empty;
  assign push      = grant_vld & (~fifo_full | pop);
  assign drop      = grant_vld & fifo_full & ~pop;
  assign overwrite = |(ev_fire & pend & ~grant_oh);

  // Pending flags: a new edge (re)loads the flag, a grant clears it.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      pend <= '0;
      for (int i = 0; i < NUM_BTNS; i++) pend_type[i] <= EVT_PRESS;
    end else begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (ev_fire[i]) begin
          pend[i]      <= 1'b1;
          pend_type[i] <= ev_type[i];
        end else if (grant_oh[i]) begin
          pend[i]      <= 1'b0;
        end
      end
    end
  end

  // Event storage; the snapshot is the debounced vector in the enqueue cycle.
  // NOTE: the storage array is not reset; the pointers alone define valid entries.
  always_ff @(posedge sys_clock) begin
    if (push) mem[wr_ptr] <= {grant_type, grant_idx, db};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: any loss wins over a clear request in the same cycle.
  always_ff @(posedge sys_clock) begin
    if (reset)                  overflow <= 1'b0;
    else if (drop || overwrite) overflow <= 1'b1;
    else if (overflow_clr)      overflow <= 1'b0;
  end

  assign fifo_count  = count;
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
  assign data_to_cpu = fifo_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_input_event_controller.sv
// Scoreboard bench for input_event_controller. Expected events are derived
// from button-level changes and queued when stimulus is applied; a monitor
// pops and compares whenever the DUT hands an event to the reader.
module tb_input_event_controller;

  localparam int NB    = 4;
  localparam int FD    = 4;
  localparam int DC    = 4;
  localparam int RD    = 20;
  localparam int RP    = 8;
  localparam int EVT_W = 8;
  localparam int CNT_W = 3;
  localparam int HOLD  = 40;

  logic             sys_clock = 1'b0;
  logic             reset;
  logic [NB-1:0]    buttons_in;
  logic             cpu_read_en;
  logic             overflow_clr;
  logic [EVT_W-1:0] data_to_cpu;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  logic [EVT_W-1:0] exp_q [$];
  int               obs_cyc [$];
  logic [NB-1:0]    cur = '0;

  bit   auto_read = 1'b0;
  logic mon_rd    = 1'b0;
  logic man_rd    = 1'b0;
  assign cpu_read_en = auto_read ? mon_rd : man_rd;

  always #5 sys_clock = ~sys_clock;
  always @(posedge sys_clock) cyc <= cyc + 1;

  input_event_controller #(
    .NUM_BTNS(NB), .FIFO_DEPTH(FD), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .sys_clock(sys_clock), .reset(reset), .buttons_in(buttons_in),
    .cpu_read_en(cpu_read_en), .overflow_clr(overflow_clr),
    .data_to_cpu(data_to_cpu), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clock);
    #1;
  endtask

  // Reference model: every changed level yields one event, in index order,
  // carrying the new level vector as its snapshot.
  task automatic apply(input logic [NB-1:0] nv);
    for (int i = 0; i < NB; i++) begin
      if (nv[i] != cur[i]) exp_q.push_back({(nv[i] ? 2'b00 : 2'b01), 2'(i), nv});
    end
    cur        = nv;
    buttons_in = nv;
  endtask

  task automatic drain(input string name);
    int t;
    auto_read = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || !fifo_empty) && t < 300) begin
      tick(1);
      t++;
    end
    check(name, (t < 300), 1);
  endtask

  task automatic pop_compare();
    logic [EVT_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got %0h, expected none (cycle %0d)", data_to_cpu, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event", data_to_cpu, e);
    end
    obs_cyc.push_back(cyc);
  endtask

  // Monitor: compare every word the reader consumes; reads at once in auto mode.
  initial begin
    forever begin
      @(negedge sys_clock);
      if (reset) begin
        mon_rd = 1'b0;
      end else begin
        if (fifo_empty) check("data_when_empty", data_to_cpu, 0);
        if (auto_read) begin
          if (!fifo_empty) begin
            pop_compare();
            mon_rd = 1'b1;
          end else begin
            mon_rd = 1'b0;
          end
        end else begin
          mon_rd = 1'b0;
          if (man_rd && !fifo_empty) pop_compare();
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int nrep;
    logic [NB-1:0] v;
    int b;
    int w;

    reset        = 1'b1;
    buttons_in   = '0;
    overflow_clr = 1'b0;
    tick(3);
    @(negedge sys_clock);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_data", data_to_cpu, 0);
    tick(1);
    reset = 1'b0;

    // Single press / release, then a short glitch that must be filtered.
    auto_read = 1'b1;
    apply(4'b0001); tick(14);
    apply(4'b0000); tick(14);
    buttons_in = 4'b0001; tick(2);
    buttons_in = 4'b0000; tick(12);
    drain("drain_single");

    // Simultaneous presses: lower index first, shared snapshot.
    apply(4'b1010); tick(14);
    apply(4'b0000); tick(14);
    drain("drain_pair");

    // Long hold on btn2: repeats only in the auto-repeat build.
    base = obs_cyc.size();
    nrep = 0;
    apply(4'b0100);
`ifdef INPUT_EVENT_AUTO_REPEAT_EN
    for (int t = RD; t < HOLD; t += RP) begin
      exp_q.push_back({2'b10, 2'd2, 4'b0100});
      nrep++;
    end
`endif
    tick(HOLD);
    apply(4'b0000); tick(14);
    drain("drain_hold");
    check("hold_event_count", obs_cyc.size() - base, 2 + nrep);
    for (int j = 0; j < nrep && (base + 1 + j) < obs_cyc.size(); j++)
      check("repeat_offset", obs_cyc[base + 1 + j] - obs_cyc[base], RD + j * RP);

    // Overflow: 4 presses fill the FIFO, the releases that follow are lost.
    auto_read = 1'b0;
    man_rd    = 1'b0;
    tick(1);
    apply(4'b1111); tick(12);
    buttons_in = 4'b0000;
    cur        = 4'b0000;
    tick(16);
    @(negedge sys_clock);
    check("ovf_full", fifo_full, 1);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    tick(1);
    overflow_clr = 1'b1; tick(1);
    overflow_clr = 1'b0;
    @(negedge sys_clock);
    check("ovf_cleared", overflow, 0);
    drain("drain_overflow");

    // Full FIFO with pop and push in the same cycles: no loss, count held.
    auto_read = 1'b0;
    tick(1);
    apply(4'b1111); tick(12);
    apply(4'b0000); tick(7);
    man_rd = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick(1);
      if (j == 3) man_rd = 1'b0;
      @(negedge sys_clock);
      check("pushpop_count", fifo_count, 4);
      check("pushpop_full", fifo_full, 1);
      check("pushpop_overflow", overflow, 0);
    end
    drain("drain_pushpop");

    // Read while empty changes nothing.
    auto_read = 1'b0;
    tick(1);
    man_rd = 1'b1; tick(3);
    man_rd = 1'b0;
    @(negedge sys_clock);
    check("empty_rd_count", fifo_count, 0);
    check("empty_rd_empty", fifo_empty, 1);
    check("empty_rd_overflow", overflow, 0);

    // Reset mid-operation with 3 events stored and btn0 still held.
    tick(1);
    buttons_in = 4'b0111; tick(14);
    @(negedge sys_clock);
    check("pre_reset_count", fifo_count, 3);
    tick(1);
    reset      = 1'b1;
    buttons_in = 4'b0001;
    tick(2);
    reset = 1'b0;
    exp_q.delete();
    cur = 4'b0000;
    @(negedge sys_clock);
    check("mid_rst_empty", fifo_empty, 1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_overflow", overflow, 0);
    auto_read = 1'b1;
    apply(4'b0001); tick(14);
    apply(4'b0000); tick(14);
    drain("drain_reset");

    // Randomised press sets, full release, and a filtered glitch.
    for (int k = 0; k < 15; k++) begin
      v = 4'($urandom_range(1, 15));
      apply(v); tick(14);
      apply(4'b0000); tick(9);
      b = $urandom_range(0, NB - 1);
      w = $urandom_range(1, 2);
      buttons_in = 4'b0001 << b; tick(w);
      buttons_in = 4'b0000; tick(5 - w);
    end
    drain("drain_random");
    tick(20);
    @(negedge sys_clock);
    check("final_no_overflow", overflow, 0);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_fifo_empty", fifo_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
